// File: rtl/bti_pkg.sv
// Shared widths, record layout, FSM states and delta arithmetic for the BTI
// frequency-sample logging path.
package bti_pkg;

  localparam int unsigned FREQ_W = 32;
  localparam int unsigned SEQ_W  = 16;
  localparam int unsigned CHAN_W = 8;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [CHAN_W-1:0] chan;
    logic [FREQ_W-1:0] count;
    logic [FREQ_W-1:0] delta;
  } bti_rec_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PUSH
  } bti_state_t;

  // Signed (a - b) of two unsigned counts, clamped to the 32-bit signed range.
  function automatic logic [FREQ_W-1:0] sat_sub(input logic [FREQ_W-1:0] a,
                                                input logic [FREQ_W-1:0] b);
    logic [FREQ_W:0] diff;
    logic [FREQ_W-1:0] res;
    diff = {1'b0, a} - {1'b0, b};
    if (!diff[FREQ_W] && diff[FREQ_W-1]) begin
      res = {1'b0, {(FREQ_W-1){1'b1}}};
    end else if (diff[FREQ_W] && !diff[FREQ_W-1]) begin
      res = {1'b1, {(FREQ_W-1){1'b0}}};
    end else begin
      res = diff[FREQ_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/bti_record_fifo.sv
// First-word-fall-through record FIFO with synchronous flush and occupancy
// output; head fields read as zero while empty.
module bti_record_fifo
  import bti_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  bti_rec_t               wr_data,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output bti_rec_t               rd_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  bti_rec_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign rd_valid = (level != '0);
  assign do_pop   = rd_valid && rd_ready;
  assign do_push  = push && (level != LW'(DEPTH));
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/freq_sample_logger.sv
// Captures each newly published (or periodically repeated) ring-oscillator
// count vector and queues one drift-tagged record per channel for readout.
module freq_sample_logger
  import bti_pkg::*;
#(
  parameter int unsigned NUM_COUNTERS   = 4,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned REPEAT_TIMEOUT = 200020
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NUM_COUNTERS*32-1:0]     freq,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [15:0]                    rd_seq,
  output logic [7:0]                     rd_chan,
  output logic [31:0]                    rd_count,
  output logic [31:0]                    rd_delta,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [15:0]                    drop_count,
  output logic [15:0]                    sample_count
);

  localparam int unsigned BUS_W  = NUM_COUNTERS * FREQ_W;
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned CH_W   = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
  localparam int unsigned TO_W   = $clog2(REPEAT_TIMEOUT + 1);

  bti_state_t        state, state_next;
  logic [BUS_W-1:0]  d1, d2, snap;
  logic [STAB_W-1:0] stab_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              enable_q;
  logic [SEQ_W-1:0]  seq;
  logic [CHAN_W-1:0] chan;
  logic [CH_W-1:0]   ch_idx;
  logic [FREQ_W-1:0] baseline [NUM_COUNTERS];
  logic [FREQ_W-1:0] snap_ch  [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] base_valid;
  logic              stable, to_hit, room;
  logic              run_start, capture, push;
  bti_rec_t          wr_rec, rd_rec;

  assign stable = (stab_cnt == STAB_W'(STABLE_CYCLES));
  assign to_hit = (to_cnt == TO_W'(REPEAT_TIMEOUT));
  assign room   = (fifo_level <= LVL_W'(FIFO_DEPTH - NUM_COUNTERS));
  assign ch_idx = chan[CH_W-1:0];

  always_comb begin
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      snap_ch[i] = snap[i*FREQ_W +: FREQ_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    run_start  = 1'b0;
    capture    = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !enable_q) begin
          run_start  = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (stable && ((d2 != snap) || to_hit)) begin
          capture = 1'b1;
          if (room) state_next = PUSH;
        end
      end
      PUSH: begin
        push = 1'b1;
        if (chan == CHAN_W'(NUM_COUNTERS - 1)) state_next = WAIT;
      end
      default: state_next = IDLE;
    endcase
    // Dropping enable abandons whatever is in flight, including a partial PUSH.
    if (!enable) begin
      state_next = IDLE;
      capture    = 1'b0;
      push       = 1'b0;
    end
  end

  always_comb begin
    wr_rec.seq   = seq;
    wr_rec.chan  = chan;
    wr_rec.count = snap_ch[ch_idx];
    wr_rec.delta = base_valid[ch_idx] ? sat_sub(snap_ch[ch_idx], baseline[ch_idx]) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d1           <= '0;
      d2           <= '0;
      snap         <= '0;
      stab_cnt     <= '0;
      to_cnt       <= '0;
      enable_q     <= 1'b0;
      seq          <= '0;
      chan         <= '0;
      sample_count <= '0;
      drop_count   <= '0;
      base_valid   <= '0;
    end else begin
      d1       <= freq;
      d2       <= d1;
      enable_q <= enable;
      if (d1 != d2)     stab_cnt <= '0;
      else if (!stable) stab_cnt <= stab_cnt + STAB_W'(1);

      if (run_start) begin
        sample_count <= '0;
        drop_count   <= '0;
        base_valid   <= '0;
        to_cnt       <= '0;
      end else if (capture) begin
        snap         <= d2;
        seq          <= sample_count;
        sample_count <= sample_count + 16'd1;
        to_cnt       <= '0;
        chan         <= '0;
        if (!room && drop_count != '1) drop_count <= drop_count + 16'd1;
      end else if (state != IDLE && !to_hit) begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (push) begin
        chan <= chan + CHAN_W'(1);
        if (!base_valid[ch_idx]) base_valid[ch_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !base_valid[ch_idx]) baseline[ch_idx] <= snap_ch[ch_idx];
  end

  bti_record_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (run_start),
    .push     (push),
    .wr_data  (wr_rec),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_rec),
    .level    (fifo_level)
  );

  assign rd_seq   = rd_rec.seq;
  assign rd_chan  = rd_rec.chan;
  assign rd_count = rd_rec.count;
  assign rd_delta = rd_rec.delta;

endmodule

// File: tb/tb_freq_sample_logger.sv
// Randomised self-checking bench for freq_sample_logger against a queue-based
// reference model of captures, baselines, drops and readout order.
module tb_freq_sample_logger;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned STAB  = 4;
  localparam int unsigned RPT   = 300;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [N*32-1:0] freq;
  logic            rd_valid;
  logic            rd_ready;
  logic [15:0]     rd_seq;
  logic [7:0]      rd_chan;
  logic [31:0]     rd_count;
  logic [31:0]     rd_delta;
  logic [4:0]      fifo_level;
  logic [15:0]     drop_count;
  logic [15:0]     sample_count;

  always #5 clk = ~clk;

  freq_sample_logger #(
    .NUM_COUNTERS   (N),
    .FIFO_DEPTH     (DEPTH),
    .STABLE_CYCLES  (STAB),
    .REPEAT_TIMEOUT (RPT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .freq         (freq),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_seq       (rd_seq),
    .rd_chan      (rd_chan),
    .rd_count     (rd_count),
    .rd_delta     (rd_delta),
    .fifo_level   (fifo_level),
    .drop_count   (drop_count),
    .sample_count (sample_count)
  );

  typedef struct {
    int unsigned seq;
    int unsigned chan;
    logic [31:0] count;
    logic [31:0] delta;
  } exp_rec_t;

  exp_rec_t    exp_q[$];
  logic [31:0] cur      [N];
  logic [31:0] last_vec [N];
  logic [31:0] base     [N];
  bit          base_set [N];
  int unsigned m_samples;
  int unsigned m_drops;
  int unsigned errors = 0;
  int unsigned checks = 0;
  int          ready_mode = 1;
  bit          mon_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_delta(input logic [31:0] c, input logic [31:0] b);
    longint d;
    d = longint'(c) - longint'(b);
    if (d > 64'sd2147483647)       d = 64'sd2147483647;
    else if (d < -64'sd2147483648) d = -64'sd2147483648;
    return d[31:0];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_samples = 0;
    m_drops   = 0;
    for (int i = 0; i < N; i++) begin
      last_vec[i] = '0;
      base_set[i] = 1'b0;
    end
  endtask

  task automatic model_capture(input bit forced);
    bit same;
    int unsigned sq;
    exp_rec_t r;
    same = 1'b1;
    for (int i = 0; i < N; i++) if (cur[i] != last_vec[i]) same = 1'b0;
    if (same && !forced) return;
    sq = m_samples % 65536;
    m_samples++;
    for (int i = 0; i < N; i++) last_vec[i] = cur[i];
    if (DEPTH - exp_q.size() >= N) begin
      for (int i = 0; i < N; i++) begin
        r.seq   = sq;
        r.chan  = i;
        r.count = cur[i];
        if (base_set[i]) begin
          r.delta = ref_delta(cur[i], base[i]);
        end else begin
          r.delta     = '0;
          base[i]     = cur[i];
          base_set[i] = 1'b1;
        end
        exp_q.push_back(r);
      end
    end else if (m_drops < 65535) begin
      m_drops++;
    end
  endtask

  task automatic apply_sample(input int hold, input bit forced);
    for (int i = 0; i < N; i++) freq[i*32 +: 32] = cur[i];
    model_capture(forced);
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int unsigned limit);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    #1;
  endtask

  task automatic start_run();
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    m_samples = 0;
    m_drops   = 0;
    for (int i = 0; i < N; i++) base_set[i] = 1'b0;
    enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 5))
        0:       cur[i] = 32'h0000_0000;
        1:       cur[i] = 32'hFFFF_FFFF;
        2:       cur[i] = cur[i];
        3:       cur[i] = cur[i] + $urandom_range(0, 40) - 20;
        default: cur[i] = $urandom;
      endcase
    end
  endtask

  initial begin
    rd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rd_ready = 1'b0;
        1:       rd_ready = 1'b1;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Head of the DUT FIFO must always match the oldest outstanding model record.
  initial begin
    exp_rec_t r;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          check("valid_when_empty", 32'(rd_valid), 32'd0);
        end else if (rd_valid) begin
          r = exp_q[0];
          check("rec_seq",   32'(rd_seq),  r.seq);
          check("rec_chan",  32'(rd_chan), r.chan);
          check("rec_count", rd_count,     r.count);
          check("rec_delta", rd_delta,     r.delta);
          if (rd_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int unsigned n;
    rst_n  = 1'b0;
    enable = 1'b0;
    freq   = '0;
    model_reset();
    for (int i = 0; i < N; i++) cur[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",  32'(rd_valid),     32'd0);
    check("rst_level",  32'(fifo_level),   32'd0);
    check("rst_drop",   32'(drop_count),   32'd0);
    check("rst_sample", 32'(sample_count), 32'd0);
    check("rst_seq",    32'(rd_seq),       32'd0);
    check("rst_chan",   32'(rd_chan),      32'd0);
    check("rst_count",  rd_count,          32'd0);
    check("rst_delta",  rd_delta,          32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First sample sets the baseline; second shows drift.
    start_run();
    cur = '{32'd1000, 32'd2000, 32'd3000, 32'd4000};
    apply_sample(1, 1'b0);
    wait_drain(200);
    check("samples_after_first", 32'(sample_count), 32'd1);
    cur = '{32'd990, 32'd2010, 32'd3000, 32'd4000};
    apply_sample(1, 1'b0);
    wait_drain(200);

    // Unchanged input is re-captured after the repeat timeout.
    apply_sample(1, 1'b1);
    wait_drain(2 * RPT);
    check("samples_after_repeat", 32'(sample_count), 32'd3);

    // Stalled consumer: four samples fill the FIFO, the fifth is dropped.
    start_run();
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) cur[i] = 32'h1000 * (k + 1) + i;
      apply_sample(16, 1'b0);
    end
    check("ovf_level",  32'(fifo_level),   32'd16);
    check("ovf_drop",   32'(drop_count),   m_drops);
    check("ovf_sample", 32'(sample_count), m_samples);
    check("ovf_valid",  32'(rd_valid),     32'd1);
    ready_mode = 1;
    wait_drain(200);

    // Delta saturation in both directions.
    start_run();
    cur = '{32'h0, 32'd5, 32'hFFFF_FFFF, 32'd7};
    apply_sample(1, 1'b0);
    wait_drain(200);
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    cur = '{32'hFFFF_FFFF, 32'd5, 32'h0, 32'd8};
    apply_sample(16, 1'b0);
    check("sat_pos_delta", rd_delta,          32'h7FFF_FFFF);
    check("sat_pos_seq",   32'(rd_seq),       32'd1);
    check("sat_pos_chan",  32'(rd_chan),      32'd0);
    ready_mode = 1;
    wait_drain(200);

    // Random vectors with a randomly stalling consumer.
    ready_mode = 2;
    repeat (30) begin
      rand_vec();
      apply_sample(1, 1'b0);
      wait_drain(300);
    end
    check("rand_samples", 32'(sample_count), m_samples);
    check("rand_drops",   32'(drop_count),   32'd0);

    // Reset in the middle of a PUSH.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    cur[0] = last_vec[0] + 32'd1;
    mon_en = 1'b0;
    apply_sample(0, 1'b0);
    n = 0;
    while (fifo_level != 5'd2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("push_progress", 32'(fifo_level), 32'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midpush_level",  32'(fifo_level),   32'd0);
    check("midpush_valid",  32'(rd_valid),     32'd0);
    check("midpush_sample", 32'(sample_count), 32'd0);
    check("midpush_seq",    32'(rd_seq),       32'd0);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    ready_mode = 1;
    start_run();
    cur = '{32'd111, 32'd222, 32'd333, 32'd444};
    apply_sample(1, 1'b0);
    wait_drain(200);
    check("post_reset_samples", 32'(sample_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
